// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter: instruction fetch and data ports share one memory slave.
// Round-robin on ties, grant held CYC..ACK, watchdog ends hung cycles with ERR.
module wb_mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 128,
  parameter int SEL_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [DATA_W-1:0] i_dat_m,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [DATA_W-1:0] i_dat_s,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_dat_m,
  input  logic [SEL_W-1:0]  d_sel,
  output logic [DATA_W-1:0] d_dat_s,
  output logic              d_ack,
  output logic              d_err,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_dat_m,
  output logic [SEL_W-1:0]  s_sel,
  input  logic [DATA_W-1:0] s_dat_s,
  input  logic              s_ack
);

  localparam int WDOG_W = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 32'sd1) : 32'sd1;
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}};
  localparam logic [WDOG_W-1:0] WDOG_ONE = WDOG_W'(1);
  localparam logic [WDOG_W-1:0] WDOG_ZERO = {WDOG_W{1'b0}};
  localparam bit   WDOG_EN = (TIMEOUT != 32'sd0);
  localparam logic PRIO_I  = 1'b0;
  localparam logic PRIO_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t            state_r;
  logic              prio_r;
  logic [WDOG_W-1:0] wdog_r;

  logic i_req_s;
  logic d_req_s;
  logic gnt_cyc_s;
  logic timeout_s;

  assign i_req_s   = i_cyc & i_stb;
  assign d_req_s   = d_cyc & d_stb;
  assign timeout_s = WDOG_EN && (wdog_r == WDOG_LIM) && !s_ack;
  assign i_dat_s   = s_dat_s;
  assign d_dat_s   = s_dat_s;

  // Slave-side mux and per-master ack/err routing for the current grant
  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = {ADDR_W{1'b0}};
    s_dat_m   = {DATA_W{1'b0}};
    s_sel     = {SEL_W{1'b0}};
    i_ack     = 1'b0;
    i_err     = 1'b0;
    d_ack     = 1'b0;
    d_err     = 1'b0;
    gnt_cyc_s = 1'b0;
    case (state_r)
      GNT_I: begin
        s_cyc     = i_req_s;
        s_stb     = i_req_s;
        s_we      = i_we;
        s_adr     = i_adr;
        s_dat_m   = i_dat_m;
        s_sel     = i_sel;
        gnt_cyc_s = i_cyc;
        // An ack landing as the master abandons is dropped, not forwarded
        i_ack     = s_ack & i_cyc;
        i_err     = timeout_s & i_cyc;
      end
      GNT_D: begin
        s_cyc     = d_req_s;
        s_stb     = d_req_s;
        s_we      = d_we;
        s_adr     = d_adr;
        s_dat_m   = d_dat_m;
        s_sel     = d_sel;
        gnt_cyc_s = d_cyc;
        d_ack     = s_ack & d_cyc;
        d_err     = timeout_s & d_cyc;
      end
      default: begin
        gnt_cyc_s = 1'b0;
      end
    endcase
  end

  // Grant FSM, round-robin priority and saturating watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      prio_r  <= PRIO_I;
      wdog_r  <= WDOG_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          wdog_r <= WDOG_ZERO;
          if (i_req_s && (!d_req_s || prio_r == PRIO_I)) begin
            state_r <= GNT_I;
          end else if (d_req_s) begin
            state_r <= GNT_D;
          end else begin
            state_r <= IDLE;
          end
        end
        GNT_I, GNT_D: begin
          if (!gnt_cyc_s) begin
            state_r <= IDLE;
          end else if (s_ack || timeout_s) begin
            // Completion (ack or watchdog) hands priority to the other master
            state_r <= IDLE;
            prio_r  <= (state_r == GNT_I) ? PRIO_D : PRIO_I;
          end else if (wdog_r != WDOG_MAX) begin
            wdog_r <= wdog_r + WDOG_ONE;
          end else begin
            wdog_r <= wdog_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter (TIMEOUT=4) with a scoreboard of expected
// master acks/errs checked whenever the arbiter returns one.
module tb_wb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 128;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_cyc, i_stb, i_we, i_ack, i_err;
  logic [AW-1:0] i_adr;
  logic [DW-1:0] i_dat_m, i_dat_s;
  logic [SW-1:0] i_sel;
  logic          d_cyc, d_stb, d_we, d_ack, d_err;
  logic [AW-1:0] d_adr;
  logic [DW-1:0] d_dat_m, d_dat_s;
  logic [SW-1:0] d_sel;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_m, s_dat_s;
  logic [SW-1:0] s_sel;

  typedef struct packed {
    logic          is_d;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_m(i_dat_m),
    .i_sel(i_sel), .i_dat_s(i_dat_s), .i_ack(i_ack), .i_err(i_err),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_m(d_dat_m),
    .d_sel(d_sel), .d_dat_s(d_dat_s), .d_ack(d_ack), .d_err(d_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_m(s_dat_m),
    .s_sel(s_sel), .s_dat_s(s_dat_s), .s_ack(s_ack)
  );

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic is_d, input logic err, input logic [DW-1:0] data);
    exp_t e;
    e.is_d = is_d;
    e.err  = err;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic mon();
    exp_t e;
    if (i_ack | d_ack | i_err | d_err) begin
      if (exp_q.size() == 0) begin
        chkw("sb_unexpected", DW'({i_ack, d_ack, i_err, d_err}), DW'(4'b0000));
      end else begin
        e = exp_q.pop_front();
        chk1("sb_i_ack", i_ack, ~e.is_d & ~e.err);
        chk1("sb_d_ack", d_ack, e.is_d & ~e.err);
        chk1("sb_i_err", i_err, ~e.is_d & e.err);
        chk1("sb_d_err", d_err, e.is_d & e.err);
        if (!e.err) chkw("sb_data", e.is_d ? d_dat_s : i_dat_s, e.data);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #2;
    mon();
  endtask

  task automatic req_i(input logic v);
    i_cyc = v;
    i_stb = v;
  endtask

  task automatic req_d(input logic v);
    d_cyc = v;
    d_stb = v;
  endtask

  initial begin
    rst_n = 1'b0;
    i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0; i_adr = 12'h010; i_dat_m = '0; i_sel = '0;
    d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_adr = 12'h3A5; d_dat_m = '0; d_sel = '0;
    s_ack = 1'b0; s_dat_s = '0;
    #2;
    chk1("rst_s_cyc", s_cyc, 1'b0);
    chk1("rst_i_ack", i_ack, 1'b0);
    chkw("rst_s_adr", DW'(s_adr), DW'(12'h000));
    tick(); tick();
    rst_n = 1'b1;
    sample();

    // Simultaneous requests out of reset: i first, d after one turnaround
    req_i(1'b1); req_d(1'b1); sample();
    chk1("t2_idle", s_cyc, 1'b0);
    tick(); s_ack = 1'b1; s_dat_s = 128'h1111; push(1'b0, 1'b0, 128'h1111); sample();
    chkw("t2_first_i", DW'(s_adr), DW'(i_adr));
    tick(); s_ack = 1'b0; req_i(1'b0); sample();
    chk1("t2_turn", s_cyc, 1'b0);
    tick(); s_ack = 1'b1; s_dat_s = 128'h2222; push(1'b1, 1'b0, 128'h2222); sample();
    chkw("t2_then_d", DW'(s_adr), DW'(d_adr));
    tick(); s_ack = 1'b0; req_d(1'b0); sample();
    chk1("t2_turn2", s_cyc, 1'b0);

    // Both held high: grants alternate I, D, I, D
    req_i(1'b1); req_d(1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(); s_ack = 1'b1; s_dat_s = DW'(k + 32'h100);
      push(k[0], 1'b0, DW'(k + 32'h100)); sample();
      chkw("t2_alt_adr", DW'(s_adr), k[0] ? DW'(d_adr) : DW'(i_adr));
      tick(); s_ack = 1'b0;
      if (k == 3) begin
        req_i(1'b0); req_d(1'b0);
      end
      sample();
      chk1("t2_alt_turn", s_cyc, 1'b0);
    end

    // Single i read with 3-cycle slave latency
    tick(); req_i(1'b1); sample();
    chk1("t1_cycle_n", s_cyc, 1'b0);
    tick(); sample();
    chkw("t1_adr", DW'(s_adr), DW'(12'h010));
    chk1("t1_cyc", s_cyc, 1'b1);
    tick(); sample();
    tick(); s_ack = 1'b1; s_dat_s = 128'hA5A5_0000_0000_0000_0000_0000_0000_5A5A;
    push(1'b0, 1'b0, 128'hA5A5_0000_0000_0000_0000_0000_0000_5A5A); sample();
    chk1("t1_i_ack", i_ack, 1'b1);
    chk1("t1_d_ack", d_ack, 1'b0);
    tick(); s_ack = 1'b0; req_i(1'b0); sample();
    chk1("t1_idle", s_cyc, 1'b0);

    // d write with i arriving mid-cycle
    tick(); d_we = 1'b1; d_sel = 16'h0003; d_dat_m = 128'hBEEF; req_d(1'b1); sample();
    tick(); req_i(1'b1); sample();
    chk1("t3_we", s_we, 1'b1);
    chkw("t3_sel", DW'(s_sel), DW'(16'h0003));
    chkw("t3_dat_m", s_dat_m, 128'hBEEF);
    chkw("t3_adr", DW'(s_adr), DW'(d_adr));
    tick(); sample();
    chk1("t3_hold_we", s_we, 1'b1);
    chkw("t3_hold_sel", DW'(s_sel), DW'(16'h0003));
    tick(); s_ack = 1'b1; s_dat_s = 128'h3333; push(1'b1, 1'b0, 128'h3333); sample();
    chk1("t3_d_ack", d_ack, 1'b1);
    chk1("t3_no_i_ack", i_ack, 1'b0);
    tick(); s_ack = 1'b0; req_d(1'b0); d_we = 1'b0; d_sel = '0; sample();
    chk1("t3_turn", s_cyc, 1'b0);
    tick(); s_ack = 1'b1; s_dat_s = 128'h4444; push(1'b0, 1'b0, 128'h4444); sample();
    chkw("t3_i_adr", DW'(s_adr), DW'(i_adr));
    chk1("t3_i_we", s_we, 1'b0);
    tick(); s_ack = 1'b0; req_i(1'b0); sample();

    // Watchdog: no ack, err on 5th granted cycle
    tick(); req_i(1'b1); sample();
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) push(1'b0, 1'b1, '0);
      sample();
      chk1("t4_err", i_err, c == 5);
      chk1("t4_cyc", s_cyc, 1'b1);
    end
    tick(); sample();
    chk1("t4_idle", s_cyc, 1'b0);
    req_i(1'b0);

    // Ack coinciding with the timeout cycle wins
    tick(); req_i(1'b1); sample();
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) begin
        s_ack = 1'b1; s_dat_s = 128'h5555; push(1'b0, 1'b0, 128'h5555);
      end
      sample();
      chk1("t4b_no_err", i_err, 1'b0);
    end
    chk1("t4b_ack", i_ack, 1'b1);
    tick(); s_ack = 1'b0; req_i(1'b0); sample();
    chk1("t4b_idle", s_cyc, 1'b0);

    // Abandon with late ack, pending d served next
    tick(); req_i(1'b1); sample();
    tick(); req_d(1'b1); sample();
    chkw("t5_gnt_i", DW'(s_adr), DW'(i_adr));
    tick(); sample();
    tick(); req_i(1'b0); s_ack = 1'b1; sample();
    chk1("t5_abandon_cyc", s_cyc, 1'b0);
    chk1("t5_no_i_ack", i_ack, 1'b0);
    tick(); sample();
    chk1("t5_idle", s_cyc, 1'b0);
    chk1("t5_late_no_d_ack", d_ack, 1'b0);
    tick(); s_ack = 1'b0; sample();
    chkw("t5_d_gnt", DW'(s_adr), DW'(d_adr));
    chk1("t5_d_cyc", s_cyc, 1'b1);
    tick(); s_ack = 1'b1; s_dat_s = 128'h6666; push(1'b1, 1'b0, 128'h6666); sample();
    tick(); s_ack = 1'b0; req_d(1'b0); sample();

    // Give d the priority, then reset mid-grant and check tie goes to i
    tick(); req_i(1'b1); sample();
    tick(); s_ack = 1'b1; s_dat_s = 128'h7777; push(1'b0, 1'b0, 128'h7777); sample();
    tick(); s_ack = 1'b0; req_i(1'b0); sample();
    tick(); req_i(1'b1); req_d(1'b1); sample();
    tick(); sample();
    chkw("t6_gnt_d", DW'(s_adr), DW'(d_adr));
    tick(); s_ack = 1'b1; rst_n = 1'b0; #1;
    chk1("t6_rst_cyc", s_cyc, 1'b0);
    chk1("t6_rst_stb", s_stb, 1'b0);
    chk1("t6_rst_ack", d_ack, 1'b0);
    sample();
    s_ack = 1'b0;
    tick(); rst_n = 1'b1; sample();
    chk1("t6_post_idle", s_cyc, 1'b0);
    tick(); s_ack = 1'b1; s_dat_s = 128'h8888; push(1'b0, 1'b0, 128'h8888); sample();
    chkw("t6_tie_i", DW'(s_adr), DW'(i_adr));
    tick(); s_ack = 1'b0; req_i(1'b0); req_d(1'b0); sample();

    chkw("sb_drain", DW'(exp_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
